vga_timing_gen: RTL and testbench

Upstream timing stage for the VGA pixel/colour logic. It divides the board clock into a pixel-rate enable strobe and runs the horizontal and vertical counters. It also decodes hsync, vsync and active-video, and produces pixel coordinates. The colour stage consumes hcount/vcount/pix_en on the same clock domain. This block replaces the separate horizontal/vertical counter pair and the slow-clock divider.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_timing_gen_if.sv | 28 ++
 rtl/vga_pix_strobe.sv | 37 +++
 rtl/vga_timing_gen.sv | 105 ++++++++++
 tb/tb_vga_timing_gen.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared timing constants and types for the VGA timing stage.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned PX_W  = 11;

  typedef logic [CNT_W-1:0] count_t;
  typedef logic [PX_W-1:0]  px_t;

  // 800x600 @ 60 Hz mode
  localparam int unsigned VGA_H_SYNC   = 128;
  localparam int unsigned VGA_H_BP     = 88;
  localparam int unsigned VGA_H_ACTIVE = 800;
  localparam int unsigned VGA_H_FP     = 40;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_SYNC + VGA_H_BP + VGA_H_ACTIVE + VGA_H_FP;

  localparam int unsigned VGA_V_SYNC   = 4;
  localparam int unsigned VGA_V_BP     = 23;
  localparam int unsigned VGA_V_ACTIVE = 600;
  localparam int unsigned VGA_V_FP     = 1;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_SYNC + VGA_V_BP + VGA_V_ACTIVE + VGA_V_FP;

  localparam int unsigned H_ACT_START = VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned H_ACT_END   = H_ACT_START + VGA_H_ACTIVE;
  localparam int unsigned V_ACT_START = VGA_V_SYNC + VGA_V_BP;
  localparam int unsigned V_ACT_END   = V_ACT_START + VGA_V_ACTIVE;

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Timing bundle from the timing generator to the colour stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic   pix_en;
  count_t hcount;
  count_t vcount;
  logic   hsync;
  logic   vsync;
  logic   active;
  px_t    px_x;
  px_t    px_y;
  logic   frame_start;

  modport master (
    output pix_en, hcount, vcount, hsync, vsync, active, px_x, px_y, frame_start
  );

  modport slave (
    input  pix_en, hcount, vcount, hsync, vsync, active, px_x, px_y, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/vga_pix_strobe.sv
`default_nettype none
// ============================================================================
// Module      : vga_pix_strobe
// Description : Phase-accumulator pixel enable, rate = clk * PIX_NUM / PIX_DEN.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pix_strobe #(
  parameter int unsigned PIX_NUM = 2,
  parameter int unsigned PIX_DEN = 5
) (
  input  logic clk,
  input  logic rst,
  output logic strobe_next,
  output logic pix_en
);
  import vga_pkg::*;

  logic [7:0] acc;
  logic [8:0] sum;

  // One extra bit so acc + PIX_NUM cannot wrap before the modulus compare.
  always_comb begin
    sum         = {1'b0, acc} + 9'(PIX_NUM);
    strobe_next = (sum >= 9'(PIX_DEN));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      pix_en <= 1'b0;
    end else begin
      acc    <= strobe_next ? 8'(sum - 9'(PIX_DEN)) : sum[7:0];
      pix_en <= strobe_next;
    end
  end
endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Pixel strobe, H/V counters and registered sync/active decode.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int unsigned PIX_NUM  = 2,
  parameter int unsigned PIX_DEN  = 5,
  parameter int unsigned H_SYNC   = vga_pkg::VGA_H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::VGA_H_BP,
  parameter int unsigned H_ACTIVE = vga_pkg::VGA_H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::VGA_H_FP,
  parameter int unsigned V_SYNC   = vga_pkg::VGA_V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::VGA_V_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::VGA_V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::VGA_V_FP,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);
  import vga_pkg::*;

  localparam count_t H_LAST   = count_t'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam count_t V_LAST   = count_t'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam count_t HS_END   = count_t'(H_SYNC);
  localparam count_t VS_END   = count_t'(V_SYNC);
  localparam count_t HA_START = count_t'(H_SYNC + H_BP);
  localparam count_t HA_END   = count_t'(H_SYNC + H_BP + H_ACTIVE);
  localparam count_t VA_START = count_t'(V_SYNC + V_BP);
  localparam count_t VA_END   = count_t'(V_SYNC + V_BP + V_ACTIVE);

  logic   strobe_next;
  logic   pix_en;
  count_t hcount, vcount;
  count_t h_next, v_next;
  logic   h_wrap;
  logic   hsync, vsync, active, frame_start;
  logic   hsync_n, vsync_n, active_n;
  px_t    px_x, px_y, px_x_n, px_y_n;

  vga_pix_strobe #(
    .PIX_NUM (PIX_NUM),
    .PIX_DEN (PIX_DEN)
  ) u_pix_strobe (
    .clk         (clk),
    .rst         (rst),
    .strobe_next (strobe_next),
    .pix_en      (pix_en)
  );

  // Decode works on the next counts so outputs move in the same clk as the counters.
  always_comb begin
    h_wrap = (hcount == H_LAST);
    h_next = h_wrap ? '0 : hcount + count_t'(1);
    v_next = vcount;
    if (h_wrap) begin
      v_next = (vcount == V_LAST) ? '0 : vcount + count_t'(1);
    end
    hsync_n  = (h_next < HS_END) ? SYNC_POL : ~SYNC_POL;
    vsync_n  = (v_next < VS_END) ? SYNC_POL : ~SYNC_POL;
    active_n = (h_next >= HA_START) && (h_next < HA_END) &&
               (v_next >= VA_START) && (v_next < VA_END);
    px_x_n   = active_n ? px_t'(h_next - HA_START) : '0;
    px_y_n   = active_n ? px_t'(v_next - VA_START) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= SYNC_POL;
      vsync       <= SYNC_POL;
      active      <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (strobe_next) begin
        hcount      <= h_next;
        vcount      <= v_next;
        hsync       <= hsync_n;
        vsync       <= vsync_n;
        active      <= active_n;
        px_x        <= px_x_n;
        px_y        <= px_y_n;
        frame_start <= (h_next == '0) && (v_next == '0);
      end
    end
  end

  assign vga.pix_en      = pix_en;
  assign vga.hcount      = hcount;
  assign vga.vcount      = vcount;
  assign vga.hsync       = hsync;
  assign vga.vsync       = vsync;
  assign vga.active      = active;
  assign vga.px_x        = px_x;
  assign vga.px_y        = px_y;
  assign vga.frame_start = frame_start;
endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed bench: default mode, 1:1 strobe mode, tiny-frame mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if ifa ();
  vga_timing_gen_if ifb ();
  vga_timing_gen_if ifc ();

  vga_timing_gen dut_a (
    .clk (clk),
    .rst (rst_a),
    .vga (ifa)
  );

  vga_timing_gen #(
    .PIX_NUM (1),
    .PIX_DEN (1)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .vga (ifb)
  );

  // Tiny frame: H 3+2+5+2 = 12, V 2+1+3+1 = 7, active low syncs.
  vga_timing_gen #(
    .PIX_NUM  (2),
    .PIX_DEN  (5),
    .H_SYNC   (3),
    .H_BP     (2),
    .H_ACTIVE (5),
    .H_FP     (2),
    .V_SYNC   (2),
    .V_BP     (1),
    .V_ACTIVE (3),
    .V_FP     (1),
    .SYNC_POL (1'b0)
  ) dut_c (
    .clk (clk),
    .rst (rst_c),
    .vga (ifc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int bad;
    int zeros;
    int prev_h;
    int prev_v;
    int exp_pat[10] = '{0, 0, 1, 0, 1, 0, 0, 1, 0, 1};
    int exp_c3[3]   = '{0, 0, 1};

    // ---------------- default mode ----------------
    @(negedge clk);
    check("a_rst_hcount", ifa.hcount, 0);
    check("a_rst_vcount", ifa.vcount, 0);
    check("a_rst_pix_en", ifa.pix_en, 0);
    check("a_rst_hsync",  ifa.hsync, 1);
    check("a_rst_vsync",  ifa.vsync, 1);
    check("a_rst_active", ifa.active, 0);
    check("a_rst_px_x",   ifa.px_x, 0);
    check("a_rst_fs",     ifa.frame_start, 0);
    rst_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("a_pix_en_clk%0d", i + 1), ifa.pix_en, exp_pat[i]);
      check($sformatf("a_fs_clk%0d", i + 1), ifa.frame_start, 0);
    end
    check("a_hcount_after10", ifa.hcount, 4);

    n = 0;
    while (ifa.hcount != 16'd127 && n < 1000) begin step(); n++; end
    check("a_reach_h127", ifa.hcount, 127);
    check("a_hsync_h127", ifa.hsync, 1);
    n = 0;
    do begin step(); n++; end while (!ifa.pix_en && n < 10);
    check("a_h128", ifa.hcount, 128);
    check("a_hsync_h128", ifa.hsync, 0);

    n = 0;
    while (ifa.hcount != 16'd1055 && n < 3000) begin step(); n++; end
    check("a_reach_h1055", ifa.hcount, 1055);
    check("a_v_line0", ifa.vcount, 0);
    n = 0;
    do begin step(); n++; end while (!ifa.pix_en && n < 10);
    check("a_hwrap_h", ifa.hcount, 0);
    check("a_hwrap_v", ifa.vcount, 1);
    check("a_hwrap_hsync", ifa.hsync, 1);
    check("a_hwrap_no_fs", ifa.frame_start, 0);

    // ---------------- 1:1 strobe, default timing ----------------
    @(negedge clk);
    rst_b = 1'b0;
    step();
    check("b_pix_en_first", ifb.pix_en, 1);
    check("b_h_first", ifb.hcount, 1);
    n = 0;
    while ((ifb.hcount != 16'd216 || ifb.vcount != 16'd27) && n < 30000) begin step(); n++; end
    check("b_reach_216_27", {ifb.hcount, ifb.vcount}, {16'd216, 16'd27});
    check("b_active_first", ifb.active, 1);
    check("b_px_x_first", ifb.px_x, 0);
    check("b_px_y_first", ifb.px_y, 0);
    check("b_hsync_deassert", ifb.hsync, 0);
    check("b_vsync_deassert", ifb.vsync, 0);
    n = 0;
    while (ifb.hcount != 16'd1015 && n < 2000) begin step(); n++; end
    check("b_px_x_last", ifb.px_x, 799);
    check("b_active_last", ifb.active, 1);
    step();
    check("b_h1016", ifb.hcount, 1016);
    check("b_active_off", ifb.active, 0);
    check("b_px_x_off", ifb.px_x, 0);
    check("b_px_y_off", ifb.px_y, 0);
    n = 0;
    while (ifb.hcount != 16'd0 && n < 2000) begin step(); n++; end
    n = 0;
    zeros = 0;
    do begin
      step();
      n++;
      if (!ifb.pix_en) zeros++;
    end while (ifb.hcount != 16'd0 && n < 2000);
    check("b_line_period", n, 1056);
    check("b_pix_en_gaps", zeros, 0);

    // ---------------- tiny frame ----------------
    @(negedge clk);
    check("c_rst_hsync", ifc.hsync, 0);
    check("c_rst_vsync", ifc.vsync, 0);
    rst_c = 1'b0;
    n = 0;
    do begin step(); n++; end while (!ifc.frame_start && n < 500);
    check("c_first_frame_delay", n, 210);
    check("c_fs_at_origin", {ifc.hcount, ifc.vcount}, 32'd0);

    bad = 0;
    prev_h = 0;
    prev_v = 0;
    for (int k = 1; k <= 210; k++) begin
      prev_h = int'(ifc.hcount);
      prev_v = int'(ifc.vcount);
      step();
      if (k < 210 && ifc.frame_start) bad++;
      if (ifc.hsync !== (ifc.hcount < 3 ? 1'b0 : 1'b1)) bad++;
      if (ifc.vsync !== (ifc.vcount < 2 ? 1'b0 : 1'b1)) bad++;
      if (ifc.hcount >= 5 && ifc.hcount < 10 && ifc.vcount >= 3 && ifc.vcount < 6) begin
        if (ifc.active !== 1'b1 || int'(ifc.px_x) != int'(ifc.hcount) - 5 ||
            int'(ifc.px_y) != int'(ifc.vcount) - 3) bad++;
      end else if (ifc.active !== 1'b0 || ifc.px_x != 0 || ifc.px_y != 0) begin
        bad++;
      end
    end
    check("c_frame_decode_bad", bad, 0);
    check("c_fs_period", ifc.frame_start, 1);
    check("c_wrap_from", {prev_h[15:0], prev_v[15:0]}, {16'd11, 16'd6});

    n = 0;
    while ((ifc.hcount != 16'd6 || ifc.vcount != 16'd4) && n < 300) begin step(); n++; end
    check("c_mid_px", {ifc.px_x, ifc.px_y}, {11'd1, 11'd1});
    #2 rst_c = 1'b1;
    #1;
    check("c_async_h", ifc.hcount, 0);
    check("c_async_v", ifc.vcount, 0);
    check("c_async_pix_en", ifc.pix_en, 0);
    check("c_async_hsync", ifc.hsync, 0);
    check("c_async_active", ifc.active, 0);
    check("c_async_px", {ifc.px_x, ifc.px_y}, 0);
    @(posedge clk);
    @(negedge clk);
    rst_c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("c_restart_pix_en_clk%0d", i + 1), ifc.pix_en, exp_c3[i]);
    end
    check("c_restart_h", ifc.hcount, 1);
    n = 3;
    do begin step(); n++; end while (!ifc.frame_start && n < 500);
    check("c_restart_frame_delay", n, 210);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
